// File: rtl/vga_timing_out_if.sv
// Pixel-side bus of the VGA timing generator: run enable, colour in,
// coordinates, strobes and the pin-mapped output byte.
interface vga_timing_out_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic          en;
  logic [7:0]    pix_rgb;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          pix_ce;
  logic          de;
  logic          frame_start;
  logic          line_start;
  logic [7:0]    uo_vga;

  modport master (
    input  en, pix_rgb,
    output hpos, vpos, pix_ce, de, frame_start, line_start, uo_vga
  );

  modport slave (
    output en, pix_rgb,
    input  hpos, vpos, pix_ce, de, frame_start, line_start, uo_vga
  );
endinterface

// File: rtl/vga_timing_out.sv
// VGA timing generator and pin formatter (legacy or PMOD pin order).
// Optional 2x2 ordered dither in PMOD mode when VGA_DITHER_EN is defined.
module vga_timing_out #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIN_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_out_if.master  bus
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [7:0] UO_IDLE = (PIN_MODE == 0) ? {7'b0, ~HS_POL}
                                                   : {~HS_POL, 3'b0, ~VS_POL, 3'b0};

  logic [DW-1:0] div;
  logic          pix_ce;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          line_start, frame_start;
  logic [7:0]    uo_vga, uo_next;
  logic          en, step, h_last, v_last;
  logic          hs, vs, de, show;
  logic [2:0]    r, g;
  logic [1:0]    b, r2, g2;

  assign en = bus.en;

  // With CLK_DIV=1 the divider never leaves 0, so pix_ce stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      pix_ce <= 1'b0;
    end else if (div == DW'(CLK_DIV - 1)) begin
      div    <= '0;
      pix_ce <= 1'b1;
    end else begin
      div    <= div + 1'b1;
      pix_ce <= 1'b0;
    end
  end

  assign step   = pix_ce & en;
  assign h_last = (hpos == HW'(H_TOTAL - 1));
  assign v_last = (vpos == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= '0;
      vpos        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= step & h_last;
      frame_start <= step & h_last & v_last;
      if (step) begin
        hpos <= h_last ? '0 : hpos + 1'b1;
        if (h_last) vpos <= v_last ? '0 : vpos + 1'b1;
      end
    end
  end

  assign hs   = ((hpos >= HW'(HS_START)) && (hpos < HW'(HS_END))) ? HS_POL : ~HS_POL;
  assign vs   = ((vpos >= VW'(VS_START)) && (vpos < VW'(VS_END))) ? VS_POL : ~VS_POL;
  assign de   = (hpos < HW'(H_ACTIVE)) && (vpos < VW'(V_ACTIVE));
  assign show = de & en;

  assign r = bus.pix_rgb[7:5];
  assign g = bus.pix_rgb[4:2];
  assign b = bus.pix_rgb[1:0];

`ifdef VGA_DITHER_EN
  if (PIN_MODE == 1) begin : g_dither
    // Only the upper threshold bit matters once the channel is cut to 2 bits.
    logic       dth;
    logic [3:0] r_sum, g_sum;
    assign dth   = hpos[0] ^ vpos[0];
    assign r_sum = {1'b0, r} + {3'b0, dth};
    assign g_sum = {1'b0, g} + {3'b0, dth};
    assign r2    = r_sum[3] ? 2'b11 : r_sum[2:1];
    assign g2    = g_sum[3] ? 2'b11 : g_sum[2:1];
  end else begin : g_trunc
    assign r2 = r[2:1];
    assign g2 = g[2:1];
  end
`else
  assign r2 = r[2:1];
  assign g2 = g[2:1];
`endif

  always_comb begin
    uo_next = UO_IDLE;
    if (PIN_MODE == 0)
      uo_next = {show ? b : 2'b0, show ? g : 3'b0, show ? r2 : 2'b0, hs};
    else
      uo_next = {hs, show & b[0], show & g2[0], show & r2[0],
                 vs, show & b[1], show & g2[1], show & r2[1]};
  end

  // One pixel behind the counters, sync and colour from the same coordinate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      uo_vga <= UO_IDLE;
    else if (pix_ce) uo_vga <= uo_next;
  end

  logic unused_bits;
  assign unused_bits = ^{vs, g, g2, r[0]};

  assign bus.hpos        = hpos;
  assign bus.vpos        = vpos;
  assign bus.pix_ce      = pix_ce;
  assign bus.de          = de;
  assign bus.line_start  = line_start;
  assign bus.frame_start = frame_start;
  assign bus.uo_vga      = uo_vga;
endmodule
